// File: rtl/rec_mux_player_if.sv
// rec_mux_player port bundle: sampled inputs, start level, UART line and status.
// master drives stimulus, slave is the recorder/player itself.
interface rec_mux_player_if #(
  parameter int CHANNELS = 3
);
  logic [CHANNELS-1:0] signals;
  logic                start;
  logic                TXD;
  logic                recording;
  logic                sending;
  logic                full;
  logic                busy;

  modport master (
    output signals, start,
    input  TXD, recording, sending, full, busy
  );

  modport slave (
    input  signals, start,
    output TXD, recording, sending, full, busy
  );
endinterface

// File: rtl/rec_mux_player.sv
// rec_mux_player: samples CHANNELS inputs into one RAM, replays each channel over UART.
// Optional trigger-armed recording when REC_TRIGGER_EN is defined.
module rec_mux_player #(
  parameter int CHANNELS   = 3,
  parameter int DEPTH      = 256,
  parameter int SAMPLE_DIV = 50,
  parameter int BAUD_DIV   = 434
) (
  input  logic CLK50MHZ,
  input  logic RST_N,
  rec_mux_player_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DEPTH / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int DW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_SEND = 2'd2
`ifdef REC_TRIGGER_EN
    , S_ARM = 2'd3
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] s1_q, s2_q;
  logic [SW-1:0]       pre_q, pre_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                full_q, full_d;
  logic [CW-1:0]       a_ch_q, a_ch_d;
  logic [BW-1:0]       a_bi_q, a_bi_d;
  logic [3:0]          a_bit_q, a_bit_d;
  logic [7:0]          a_sh_q, a_sh_d;
  logic                a_done_q, a_done_d;
  logic [7:0]          nxt_q, nxt_d;
  logic                nxt_vld_q, nxt_vld_d;
  logic [9:0]          fr_q, fr_d;
  logic [DW-1:0]       bd_q, bd_d;
  logic [3:0]          bt_q, bt_d;
  logic                act_q, act_d;
  logic [CHANNELS-1:0] rd_q;
  logic [AW-1:0]       rd_addr;
  logic                we;
  logic                load;
  logic [CHANNELS-1:0] mem [DEPTH];

`ifdef REC_TRIGGER_EN
  logic [CHANNELS-1:0] pv_q;

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) pv_q <= '0;
    else        pv_q <= s2_q;
  end
`endif

  // Byte k of a channel reads addresses 8k..8k+7; a_bi_q is 1-based for data.
  assign rd_addr = AW'({a_bi_q - BW'(1), 3'b000}) | AW'(a_bit_q[2:0]);

  always_ff @(posedge CLK50MHZ) begin
    if (we) mem[addr_q] <= s2_q;
    rd_q <= mem[rd_addr];
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    addr_d    = addr_q;
    full_d    = full_q;
    a_ch_d    = a_ch_q;
    a_bi_d    = a_bi_q;
    a_bit_d   = a_bit_q;
    a_sh_d    = a_sh_q;
    a_done_d  = a_done_q;
    nxt_d     = nxt_q;
    nxt_vld_d = nxt_vld_q;
    fr_d      = fr_q;
    bd_d      = bd_q;
    bt_d      = bt_q;
    act_d     = act_q;
    we        = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        pre_d     = '0;
        addr_d    = '0;
        full_d    = 1'b0;
        a_ch_d    = '0;
        a_bi_d    = '0;
        a_bit_d   = '0;
        a_done_d  = 1'b0;
        nxt_vld_d = 1'b0;
        fr_d      = '1;
        bd_d      = '0;
        bt_d      = '0;
        act_d     = 1'b0;
        if (bus.start) begin
`ifdef REC_TRIGGER_EN
          state_d = S_ARM;
`else
          state_d = S_REC;
`endif
        end
      end
`ifdef REC_TRIGGER_EN
      S_ARM: begin
        if (s2_q != pv_q) state_d = S_REC;
      end
`endif
      S_REC: begin
        pre_d = (pre_q == SW'(SAMPLE_DIV - 1)) ? '0 : pre_q + SW'(1);
        if (pre_q == '0) begin
          we     = 1'b1;
          addr_d = addr_q + AW'(1);
          if (addr_q == AW'(DEPTH - 1)) begin
            full_d  = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        // Assembler fills nxt_q while the current frame is on the wire.
        if (!nxt_vld_q && !a_done_q) begin
          if (a_bi_q == '0) begin
            nxt_d     = 8'hA0 | 8'(a_ch_q);
            nxt_vld_d = 1'b1;
            a_bi_d    = BW'(1);
          end else if (a_bit_q == 4'd8) begin
            nxt_d     = {rd_q[a_ch_q], a_sh_q[7:1]};
            nxt_vld_d = 1'b1;
            a_bit_d   = '0;
            if (a_bi_q == BW'(NB)) begin
              a_bi_d = '0;
              if (a_ch_q == CW'(CHANNELS - 1)) a_done_d = 1'b1;
              else                             a_ch_d   = a_ch_q + CW'(1);
            end else begin
              a_bi_d = a_bi_q + BW'(1);
            end
          end else begin
            a_bit_d = a_bit_q + 4'd1;
            if (a_bit_q != 4'd0) a_sh_d = {rd_q[a_ch_q], a_sh_q[7:1]};
          end
        end
        if (!act_q) begin
          load = nxt_vld_q;
        end else if (bd_q == DW'(BAUD_DIV - 1)) begin
          bd_d = '0;
          if (bt_q == 4'd9) begin
            if (nxt_vld_q) begin
              load = 1'b1;
            end else begin
              act_d = 1'b0;
              fr_d  = '1;
              if (a_done_q) begin
                full_d  = 1'b0;
                state_d = S_IDLE;
              end
            end
          end else begin
            bt_d = bt_q + 4'd1;
            fr_d = {1'b1, fr_q[9:1]};
          end
        end else begin
          bd_d = bd_q + DW'(1);
        end
        if (load) begin
          fr_d      = {1'b1, nxt_q, 1'b0};
          nxt_vld_d = 1'b0;
          act_d     = 1'b1;
          bd_d      = '0;
          bt_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      s1_q      <= '0;
      s2_q      <= '0;
      pre_q     <= '0;
      addr_q    <= '0;
      full_q    <= 1'b0;
      a_ch_q    <= '0;
      a_bi_q    <= '0;
      a_bit_q   <= '0;
      a_sh_q    <= '0;
      a_done_q  <= 1'b0;
      nxt_q     <= '0;
      nxt_vld_q <= 1'b0;
      fr_q      <= '1;
      bd_q      <= '0;
      bt_q      <= '0;
      act_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= bus.signals;
      s2_q      <= s1_q;
      pre_q     <= pre_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      a_ch_q    <= a_ch_d;
      a_bi_q    <= a_bi_d;
      a_bit_q   <= a_bit_d;
      a_sh_q    <= a_sh_d;
      a_done_q  <= a_done_d;
      nxt_q     <= nxt_d;
      nxt_vld_q <= nxt_vld_d;
      fr_q      <= fr_d;
      bd_q      <= bd_d;
      bt_q      <= bt_d;
      act_q     <= act_d;
    end
  end

  assign bus.TXD     = fr_q[0];
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.sending = (state_q == S_SEND);
  assign bus.full    = full_q;
`ifdef REC_TRIGGER_EN
  assign bus.recording = (state_q == S_REC) || (state_q == S_ARM);
`else
  assign bus.recording = (state_q == S_REC);
`endif
endmodule

// File: tb/tb_rec_mux_player.sv
// Scoreboard bench for rec_mux_player: UART decoder pops expected bytes from a queue.
// Trigger scenario is compiled in when REC_TRIGGER_EN is defined.
`timescale 1ns/1ps
module tb_rec_mux_player;
  localparam int CH = 3;
  localparam int DEPTH = 16;
  localparam int SDIV = 4;
  localparam int BDIV = 8;
  localparam int FRAME_NS = 10 * BDIV * 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  rec_mux_player_if #(.CHANNELS(CH)) bus ();

  rec_mux_player #(
    .CHANNELS(CH), .DEPTH(DEPTH), .SAMPLE_DIV(SDIV), .BAUD_DIV(BDIV)
  ) dut (
    .CLK50MHZ(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         first;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            frames = 0;
  time           t_full = 0;
  time           t_last = 0;
  logic          full_p = 1'b0;
  logic [CH-1:0] seq [0:127];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void pushb(input logic [7:0] b, input bit first);
    exp_t e;
    e.b = b;
    e.first = first;
    exp_q.push_back(e);
  endfunction

  // Reference: sample n is seq[SDIV*n]; byte k of ch packs samples 8k..8k+7.
  function automatic void model_push();
    logic [7:0] b;
    for (int ch = 0; ch < CH; ch++) begin
      pushb(8'hA0 | 8'(ch), ch == 0);
      for (int k = 0; k < DEPTH / 8; k++) begin
        for (int j = 0; j < 8; j++) b[j] = seq[SDIV * (8 * k + j)][ch];
        pushb(b, 1'b0);
      end
    end
  endfunction

  function automatic void push_lit(input logic [7:0] d0, input logic [7:0] d1,
                                   input logic [7:0] d2);
    logic [7:0] d;
    for (int ch = 0; ch < CH; ch++) begin
      d = (ch == 0) ? d0 : (ch == 1) ? d1 : d2;
      pushb(8'hA0 | 8'(ch), ch == 0);
      for (int k = 0; k < DEPTH / 8; k++) pushb(d, 1'b0);
    end
  endfunction

  function automatic void fill_rand();
    for (int i = 0; i < 128; i++) seq[i] = CH'($urandom);
  endfunction

  task automatic launch(input bit rej);
    @(posedge clk); #2 bus.signals = seq[0];
    @(posedge clk); #2 bus.start = 1'b1; bus.signals = seq[1];
    for (int i = 2; i < 128; i++) begin
      @(posedge clk); #2;
      bus.signals = seq[i];
      bus.start = rej && (i == 20 || i == 100);
      if (rej && i == 20) chk("rej_in_record", 32'(bus.recording), 32'd1);
      if (rej && i == 100) chk("rej_in_send", 32'(bus.sending), 32'd1);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_budget"}, 32'(n < 3000), 32'd1);
    chk({tag, "_busy_drop_ns"}, 32'($time - t_last), 32'(FRAME_NS));
    chk({tag, "_status_idle"},
        32'({bus.recording, bus.sending, bus.full}), 32'd0);
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (bus.full && !full_p) t_full <= $time;
    full_p <= bus.full;
  end

  // UART monitor: samples mid-bit, abandons a frame cut short by reset.
  initial begin : monitor
    logic [9:0] bits;
    bit         ab;
    time        ts;
    time        prev;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.TXD === 1'b0) begin
        ts = $time;
        prev = t_last;
        t_last = ts;
        frames++;
        ab = 1'b0;
        for (int c = 0; c < 76; c++) begin
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
          if (c >= 3 && (c - 3) % 8 == 0) bits[(c - 3) / 8] = bus.TXD;
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(bits[8:1]), 32'h100);
          end else begin
            e = exp_q.pop_front();
            chk("frame_start_bit", 32'(bits[0]), 32'd0);
            chk("frame_stop_bit", 32'(bits[9]), 32'd1);
            chk("byte_value", 32'(bits[8:1]), 32'(e.b));
            if (e.first) chk("hdr_latency_le3", 32'((ts - t_full) <= 30), 32'd1);
            else         chk("byte_gap_ns", 32'(ts - prev), 32'(FRAME_NS));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int f0;
    bus.signals = '0;
    bus.start = 1'b0;
    #1 rst_n = 1'b0;
    repeat (20) begin
      @(posedge clk); #2;
      bus.signals = CH'($urandom);
      bus.start = 1'($urandom);
      @(negedge clk);
      chk("rst_txd", 32'(bus.TXD), 32'd1);
      chk("rst_status",
          32'({bus.recording, bus.sending, bus.full, bus.busy}), 32'd0);
    end
    @(posedge clk); #2 bus.start = 1'b0; rst_n = 1'b1;
    repeat (500) begin
      @(negedge clk);
      chk("idle_txd", 32'(bus.TXD), 32'd1);
    end
`ifndef REC_TRIGGER_EN
    for (int i = 0; i < 128; i++) seq[i] = 3'b101;
    push_lit(8'hFF, 8'h00, 8'hFF);
    launch(1'b0);
    wait_done("const");

    for (int i = 0; i < 128; i++) seq[i] = {2'b00, ((i / 4) % 2 == 0)};
    push_lit(8'h55, 8'h00, 8'h00);
    launch(1'b0);
    wait_done("toggle");

    repeat (3) begin
      fill_rand();
      model_push();
      launch(1'b0);
      wait_done("rand");
    end

    fill_rand();
    model_push();
    f0 = frames;
    launch(1'b1);
    wait_done("rej");
    repeat (300) @(negedge clk);
    chk("rej_frame_count", 32'(frames - f0), 32'd9);
    chk("rej_stays_idle", 32'(bus.busy), 32'd0);

    fill_rand();
    model_push();
    f0 = frames;
    launch(1'b0);
    n = 0;
    while (frames < f0 + 6 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_ch1_byte2", 32'(n < 2000), 32'd1);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txd_now", 32'(bus.TXD), 32'd1);
    chk("abort_status_now",
        32'({bus.recording, bus.sending, bus.full, bus.busy}), 32'd0);
    exp_q.delete();
    repeat (10) begin
      @(negedge clk);
      chk("abort_hold", 32'({bus.TXD, bus.busy, bus.full}), 32'b100);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_no_resume", 32'({bus.TXD, bus.busy}), 32'b10);

    fill_rand();
    model_push();
    launch(1'b0);
    wait_done("restart");
`else
    @(posedge clk); #2 bus.signals = 3'b011;
    repeat (10) @(posedge clk);
    #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      chk("arm_recording", 32'(bus.recording), 32'd1);
      chk("arm_txd_idle", 32'(bus.TXD), 32'd1);
    end
    push_lit(8'hFF, 8'hFF, 8'hFF);
    @(posedge clk); #2 bus.signals = 3'b111;
    repeat (5) @(negedge clk);
    wait_done("trig");
`endif
    repeat (50) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rec_mux_player.md
# rec_mux_player

Multi-channel capture-and-replay block: samples CHANNELS single-bit inputs simultaneously into a shared on-chip buffer at a programmable rate, then streams each channel's record over a single RS-232 TXD line, one channel after another. It replaces per-signal recorder instances that each need their own transmitter. A single arbitrated UART output removes contention on TXD. Sits between board inputs (rotary encoder lines, buttons) and the FPGA TXD pin.

## Interface
- CHANNELS, 3, number of sampled inputs (1..8)
- DEPTH, 256, samples per channel; multiple of 8, power of two
- SAMPLE_DIV, 50, clock cycles between samples (≥2)
- BAUD_DIV, 434, clock cycles per UART bit (115200 baud at 50 MHz; ≥2)

- CLK50MHZ  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- signals  in  CHANNELS  sampled inputs; each bit double-flopped inside the block before use
- start  in  1  level; accepted only in IDLE
- TXD  out  1  UART 8N1, LSB first, idle high
- recording  out  1  high in ARM and RECORD states
- sending  out  1  high in SEND state
- full  out  1  high from buffer-full until SEND ends
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ARM (only with REC_TRIGGER_EN), RECORD, SEND.
- IDLE: start=1 goes to RECORD, or to ARM with REC_TRIGGER_EN. Sample address and prescaler are cleared.
- RECORD: sample 0 is captured on the first clock in RECORD. Each later sample comes SAMPLE_DIV cycles after the previous one. The synchronised signals vector is written to mem[addr], width CHANNELS. addr counts 0..DEPTH-1.
- After sample DEPTH-1: full=1, next state SEND.
- SEND, per channel ch = 0..CHANNELS-1:
  - First a header byte 8'hA0 | ch.
  - Then DEPTH/8 data bytes. Byte k holds bit ch of samples 8k..8k+7, with sample 8k in bit 0.
  - Data bytes are assembled by reading 8 consecutive addresses. Assembly overlaps the previous byte's transmission.
- Total bytes sent = CHANNELS*(1+DEPTH/8). After the last stop bit: full=0, state IDLE.
- start is ignored outside IDLE. If start is still high on return to IDLE, a new recording begins.
- Memory may infer block RAM with synchronous read. Read latency is hidden inside byte assembly.

## Timing
- Reset values:
  - TXD=1; recording=sending=full=busy=0.
  - State IDLE; all counters 0.
  - Memory contents are undefined.
- Reset asserted mid-operation aborts at once. TXD returns high asynchronously, which may truncate a frame. Nothing resumes after release.
- start sampled high at edge t: busy=1 and recording=1 from t+1. Sample 0 is taken at edge t+1 (no trigger build).
- Sample n is taken at edge t+1+n*SAMPLE_DIV. full rises one cycle after the edge that takes sample DEPTH-1.
- The header start bit begins ≤3 cycles after full rises.
- UART frame: 1 start bit (0), 8 data bits, 1 stop bit (1), each BAUD_DIV cycles, so 10*BAUD_DIV cycles per byte.
- Bytes are back-to-back with no idle gap, including across channel boundaries.
- sending drops, and busy drops, on the cycle after the last stop bit completes.
- Input synchroniser latency is 2 cycles. A sample reflects the signals value 2 cycles before the capture edge.

## Configuration
- REC_TRIGGER_EN defined:
  - start enters ARM (recording=1, nothing stored).
  - The first cycle in which any synchronised channel differs from its previous synchronised value moves to RECORD. Sample 0 is captured on that transition's next edge.
  - ARM waits indefinitely.
- REC_TRIGGER_EN undefined: the ARM state and edge detector are absent, and start goes directly to RECORD.

## Test plan
Use CHANNELS=3, DEPTH=16, SAMPLE_DIV=4, BAUD_DIV=8.
- Reset check: hold RST_N=0 with random signals and start -> TXD=1, all status outputs 0 throughout. After release with start=0 for 500 cycles -> TXD stays 1.
- Constant pattern: signals=3'b101, pulse start -> decoded bytes A0,FF,FF,A1,00,00,A2,FF,FF. Each frame is 80 cycles, with no gaps. busy drops after the 9th stop bit.
- Toggle: ch0 flips every 4 cycles, in phase with sampling, so samples alternate 1,0,…; ch1=ch2=0 -> A0,55,55,A1,00,00,A2,00,00.
- Busy rejection: assert start again during RECORD and during SEND -> exactly 9 bytes. A new sequence starts only once start is seen in IDLE.
- Abort: drop RST_N during the second data byte of ch1 -> TXD=1 the same cycle, all outputs 0. A new start then yields a complete sequence beginning with A0.
- Trigger (REC_TRIGGER_EN): start with signals static for 1000 cycles -> recording=1, no TXD activity. Rise ch2 -> recording proceeds. The first data bit for ch2 reflects the post-edge level.
